// File: rtl/pattern_stream_if.sv
// Beat stream between a FIFO-style source and the pattern checker.
// The source drives data/valid; the checker answers with pattern_adv.
interface pattern_stream_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic        pattern_adv;

  modport master (
    output data_in,
    output data_valid,
    input  pattern_adv
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output pattern_adv
  );
endinterface

// File: rtl/pattern_stream_checker.sv
// Checks a 32-bit beat stream against a counter/walk/LFSR/alternating pattern.
// Define PATTERN_CHECKER_FIRST_ERR_EN to capture the first mismatching beat.
module pattern_stream_checker #(
  parameter int CNT_W   = 32,
  parameter bit ERR_SAT = 1'b1
) (
  input  logic             okClk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       pattern_sel,
  input  logic [31:0]      seed,
  pattern_stream_if.slave  s_if,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] beat_count,
  output logic             err_flag,
  output logic [31:0]      first_err_beat,
  output logic [31:0]      first_err_data,
  output logic [31:0]      first_err_exp,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_CNT  = 2'd0;
  localparam logic [1:0] M_WALK = 2'd1;
  localparam logic [1:0] M_LFSR = 2'd2;
  localparam logic [1:0] M_ALT  = 2'd3;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       r_mode;
  logic [31:0]      r_exp;
  logic [31:0]      w_exp_adv;
  logic [31:0]      w_exp_load;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_err_flag;

  logic             w_run;
  logic             w_beat;
  logic             w_load;
  logic             w_mis;

  // Assert asynchronously, release two okClk edges after reset_n rises.
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  function automatic logic [CNT_W-1:0] f_inc(
    input logic [CNT_W-1:0] v
  );
    logic [CNT_W-1:0] n;
    n = v + CNT_W'(1);
    if (ERR_SAT && (&v)) begin
      n = v;
    end
    return n;
  endfunction

  assign w_run  = (r_state == S_RUN);
  // Beats coinciding with any control pulse are dropped, not checked.
  assign w_beat = w_run & s_if.data_valid & ~clear & ~stop & ~start;
  assign w_load = start & ~stop & ~clear & ~w_run;
  assign w_mis  = w_beat & (s_if.data_in != r_exp);

  assign s_if.pattern_adv = w_beat;

  always_comb begin
    w_exp_load = seed;
    unique case (pattern_sel)
      M_CNT:  w_exp_load = seed;
      M_WALK: w_exp_load = 32'h1;
      M_LFSR: w_exp_load = (seed == 32'h0) ? 32'h1 : seed;
      M_ALT:  w_exp_load = seed;
    endcase
  end

  always_comb begin
    w_exp_adv = r_exp;
    unique case (r_mode)
      M_CNT:  w_exp_adv = r_exp + 32'h1;
      M_WALK: w_exp_adv = {r_exp[30:0], r_exp[31]};
      M_LFSR: w_exp_adv = {r_exp[30:0],
                           r_exp[31] ^ r_exp[21] ^
                           r_exp[1] ^ r_exp[0]};
      M_ALT:  w_exp_adv = ~r_exp;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    priority case (1'b1)
      clear:  w_state_nxt = S_IDLE;
      stop:   w_state_nxt = w_run ? S_DONE : r_state;
      w_load: w_state_nxt = S_RUN;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge okClk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= M_CNT;
      r_exp   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (clear) begin
        r_mode <= M_CNT;
        r_exp  <= 32'h0;
      end else if (w_load) begin
        r_mode <= pattern_sel;
        r_exp  <= w_exp_load;
      end else if (w_beat) begin
        r_exp  <= w_exp_adv;
      end
    end
  end

  always_ff @(posedge okClk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else if (clear) begin
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else if (w_beat) begin
      r_beat_cnt <= f_inc(r_beat_cnt);
      if (w_mis) begin
        r_err_cnt  <= f_inc(r_err_cnt);
        r_err_flag <= 1'b1;
      end
    end
  end

  assign beat_count  = r_beat_cnt;
  assign error_count = r_err_cnt;
  assign err_flag    = r_err_flag;
  assign busy        = w_run;

`ifdef PATTERN_CHECKER_FIRST_ERR_EN
  logic [31:0] r_fe_beat;
  logic [31:0] r_fe_data;
  logic [31:0] r_fe_exp;

  // err_flag low means no mismatch has been captured since clear.
  always_ff @(posedge okClk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fe_beat <= 32'h0;
      r_fe_data <= 32'h0;
      r_fe_exp  <= 32'h0;
    end else if (clear) begin
      r_fe_beat <= 32'h0;
      r_fe_data <= 32'h0;
      r_fe_exp  <= 32'h0;
    end else if (w_mis && !r_err_flag) begin
      r_fe_beat <= 32'(r_beat_cnt);
      r_fe_data <= s_if.data_in;
      r_fe_exp  <= r_exp;
    end
  end

  assign first_err_beat = r_fe_beat;
  assign first_err_data = r_fe_data;
  assign first_err_exp  = r_fe_exp;
`else
  assign first_err_beat = 32'h0;
  assign first_err_data = 32'h0;
  assign first_err_exp  = 32'h0;
`endif

endmodule

// File: tb/tb_pattern_stream_checker.sv
// Directed bench for pattern_stream_checker, including 16-bit
// saturating and wrapping counter instances.
module tb_pattern_stream_checker;

`ifdef PATTERN_CHECKER_FIRST_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        okClk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [31:0] seed = 32'h0;

  logic [31:0] error_count, beat_count;
  logic        err_flag, busy;
  logic [31:0] fe_beat, fe_data, fe_exp;

  logic [15:0] s_err, s_beat, w_err, w_beat;
  logic        s_flag, w_flag, s_busy, w_busy;
  logic [31:0] s_fb, s_fd, s_fx, w_fb, w_fd, w_fx;

  int errors = 0;
  int checks = 0;

  pattern_stream_if sif();
  pattern_stream_if sif_s();
  pattern_stream_if sif_w();

  assign sif_s.data_in    = sif.data_in;
  assign sif_s.data_valid = sif.data_valid;
  assign sif_w.data_in    = sif.data_in;
  assign sif_w.data_valid = sif.data_valid;

  always #5 okClk = ~okClk;

  pattern_stream_checker u_dut (
    .okClk(okClk), .reset_n(reset_n), .clear(clear),
    .start(start), .stop(stop), .pattern_sel(pattern_sel),
    .seed(seed), .s_if(sif),
    .error_count(error_count), .beat_count(beat_count),
    .err_flag(err_flag), .first_err_beat(fe_beat),
    .first_err_data(fe_data), .first_err_exp(fe_exp),
    .busy(busy)
  );

  pattern_stream_checker #(.CNT_W(16), .ERR_SAT(1'b1)) u_sat (
    .okClk(okClk), .reset_n(reset_n), .clear(clear),
    .start(start), .stop(stop), .pattern_sel(pattern_sel),
    .seed(seed), .s_if(sif_s),
    .error_count(s_err), .beat_count(s_beat),
    .err_flag(s_flag), .first_err_beat(s_fb),
    .first_err_data(s_fd), .first_err_exp(s_fx),
    .busy(s_busy)
  );

  pattern_stream_checker #(.CNT_W(16), .ERR_SAT(1'b0)) u_wrap (
    .okClk(okClk), .reset_n(reset_n), .clear(clear),
    .start(start), .stop(stop), .pattern_sel(pattern_sel),
    .seed(seed), .s_if(sif_w),
    .error_count(w_err), .beat_count(w_beat),
    .err_flag(w_flag), .first_err_beat(w_fb),
    .first_err_data(w_fd), .first_err_exp(w_fx),
    .busy(w_busy)
  );

  task automatic cyc();
    @(posedge okClk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] sel, input logic [31:0] sd);
    pattern_sel = sel;
    seed = sd;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    sif.data_in = d;
    sif.data_valid = 1'b1;
    cyc();
    sif.data_valid = 1'b0;
  endtask

  function automatic logic [31:0] lfsr(input logic [31:0] e);
    return {e[30:0], e[31] ^ e[21] ^ e[1] ^ e[0]};
  endfunction

  task automatic test_reset();
    sif.data_in = 32'h0;
    sif.data_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %0b want 0", busy);
    end
    checks++;
    if (beat_count !== 32'h0 || error_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %0h/%0h want 0/0", beat_count, error_count);
    end
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_flag: got %0b want 0", err_flag);
    end
    checks++;
    if ({fe_beat, fe_data, fe_exp} !== 96'h0) begin
      errors++;
      $display("FAIL reset_fe: got %0h %0h %0h want 0", fe_beat, fe_data, fe_exp);
    end
  endtask

  task automatic test_idle_ignore();
    do_clear();
    sif.data_in = 32'h0;
    sif.data_valid = 1'b1;
    #1;
    checks++;
    if (sif.pattern_adv !== 1'b0) begin
      errors++;
      $display("FAIL idle_adv: got %0b want 0", sif.pattern_adv);
    end
    repeat (3) cyc();
    sif.data_valid = 1'b0;
    checks++;
    if (beat_count !== 32'h0) begin
      errors++;
      $display("FAIL idle_beats: got %0h want 0", beat_count);
    end
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_start_stop: busy got %0b want 0", busy);
    end
  endtask

  task automatic test_counter();
    do_clear();
    do_start(2'd0, 32'h10);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cnt_busy: got %0b want 1", busy);
    end
    sif.data_in = 32'h10;
    sif.data_valid = 1'b1;
    #1;
    checks++;
    if (sif.pattern_adv !== 1'b1) begin
      errors++;
      $display("FAIL cnt_adv: got %0b want 1", sif.pattern_adv);
    end
    for (int i = 0; i < 8; i++) beat(32'h10 + 32'(i));
    checks++;
    if (beat_count !== 32'd8) begin
      errors++;
      $display("FAIL cnt_beats: got %0h want 8", beat_count);
    end
    do_stop();
    checks++;
    if (error_count !== 32'h0 || err_flag !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cnt_result: err %0h flag %0b busy %0b want 0 0 0", error_count, err_flag, busy);
    end
  endtask

  task automatic test_first_err();
    do_clear();
    do_start(2'd0, 32'h0);
    beat(32'h0);
    beat(32'h1);
    beat(32'hDEAD);
    beat(32'h3);
    do_stop();
    checks++;
    if (error_count !== 32'd1 || beat_count !== 32'd4 || err_flag !== 1'b1) begin
      errors++;
      $display("FAIL fe_counts: err %0h beats %0h flag %0b want 1 4 1", error_count, beat_count, err_flag);
    end
    checks++;
    if (fe_beat !== (FE ? 32'd2 : 32'd0)) begin
      errors++;
      $display("FAIL fe_beat: got %0h want %0h", fe_beat, FE ? 32'd2 : 32'd0);
    end
    checks++;
    if (fe_data !== (FE ? 32'hDEAD : 32'd0)) begin
      errors++;
      $display("FAIL fe_data: got %0h want %0h", fe_data, FE ? 32'hDEAD : 32'd0);
    end
    checks++;
    if (fe_exp !== (FE ? 32'd2 : 32'd0)) begin
      errors++;
      $display("FAIL fe_exp: got %0h want %0h", fe_exp, FE ? 32'd2 : 32'd0);
    end
  endtask

  task automatic test_lfsr();
    logic [31:0] e;
    do_clear();
    do_start(2'd2, 32'h0);
    pattern_sel = 2'd0;
    seed = 32'h5;
    beat(32'h1);
    checks++;
    if (error_count !== 32'h0) begin
      errors++;
      $display("FAIL lfsr_first: err got %0h want 0", error_count);
    end
    e = lfsr(32'h1);
    for (int i = 1; i < 1000; i++) begin
      sif.data_in = e;
      sif.data_valid = 1'b1;
      cyc();
      e = lfsr(e);
    end
    sif.data_valid = 1'b0;
    do_stop();
    checks++;
    if (error_count !== 32'h0 || beat_count !== 32'd1000) begin
      errors++;
      $display("FAIL lfsr_run: err %0h beats %0d want 0 1000", error_count, beat_count);
    end
  endtask

  task automatic test_walk_stop_clear();
    do_clear();
    do_start(2'd1, 32'hFFFF);
    beat(32'h1);
    beat(32'h2);
    beat(32'h4);
    stop = 1'b1;
    sif.data_in = 32'h8;
    sif.data_valid = 1'b1;
    #1;
    checks++;
    if (sif.pattern_adv !== 1'b0) begin
      errors++;
      $display("FAIL walk_stop_adv: got %0b want 0", sif.pattern_adv);
    end
    cyc();
    stop = 1'b0;
    sif.data_valid = 1'b0;
    checks++;
    if (beat_count !== 32'd3 || busy !== 1'b0 || error_count !== 32'h0) begin
      errors++;
      $display("FAIL walk_stop: beats %0h busy %0b err %0h want 3 0 0", beat_count, busy, error_count);
    end
    do_start(2'd1, 32'h0);
    beat(32'h1);
    checks++;
    if (beat_count !== 32'd4 || error_count !== 32'h0) begin
      errors++;
      $display("FAIL walk_restart: beats %0h err %0h want 4 0", beat_count, error_count);
    end
    do_stop();
    clear = 1'b1;
    start = 1'b1;
    cyc();
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if (beat_count !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL walk_clear: beats %0h busy %0b want 0 0", beat_count, busy);
    end
  endtask

  task automatic test_alt();
    do_clear();
    pattern_sel = 2'd3;
    seed = 32'hA5A5_0F0F;
    start = 1'b1;
    sif.data_in = 32'h0;
    sif.data_valid = 1'b1;
    cyc();
    start = 1'b0;
    sif.data_valid = 1'b0;
    checks++;
    if (beat_count !== 32'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL alt_start_beat: beats %0h busy %0b want 0 1", beat_count, busy);
    end
    beat(32'hA5A5_0F0F);
    beat(32'h5A5A_F0F0);
    beat(32'hA5A5_0F0F);
    beat(32'h1234_5678);
    do_stop();
    checks++;
    if (error_count !== 32'd1 || beat_count !== 32'd4) begin
      errors++;
      $display("FAIL alt_counts: err %0h beats %0h want 1 4", error_count, beat_count);
    end
    checks++;
    if (fe_exp !== (FE ? 32'h5A5A_F0F0 : 32'h0) || fe_beat !== (FE ? 32'd3 : 32'd0)) begin
      errors++;
      $display("FAIL alt_fe: exp %0h beat %0h want %0h %0h", fe_exp, fe_beat, FE ? 32'h5A5A_F0F0 : 32'h0, FE ? 32'd3 : 32'd0);
    end
  endtask

  task automatic test_reset_mid_run();
    do_clear();
    do_start(2'd0, 32'h0);
    beat(32'h77);
    sif.data_in = 32'h1;
    sif.data_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (sif.pattern_adv !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_adv: adv %0b busy %0b want 0 0", sif.pattern_adv, busy);
    end
    checks++;
    if (beat_count !== 32'h0 || error_count !== 32'h0 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_cnt: beats %0h err %0h flag %0b want 0", beat_count, error_count, err_flag);
    end
    checks++;
    if ({fe_beat, fe_data, fe_exp} !== 96'h0) begin
      errors++;
      $display("FAIL rst_run_fe: got %0h %0h %0h want 0", fe_beat, fe_data, fe_exp);
    end
    cyc();
    sif.data_valid = 1'b0;
    reset_n = 1'b1;
    repeat (3) cyc();
    checks++;
    if (busy !== 1'b0 || beat_count !== 32'h0) begin
      errors++;
      $display("FAIL rst_run_release: busy %0b beats %0h want 0 0", busy, beat_count);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    do_start(2'd0, 32'h0);
    sif.data_in = 32'hFFFF_FFFF;
    sif.data_valid = 1'b1;
    repeat (70000) cyc();
    sif.data_valid = 1'b0;
    do_stop();
    checks++;
    if (s_err !== 16'hFFFF || s_beat !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: err %0h beats %0h want ffff ffff", s_err, s_beat);
    end
    checks++;
    if (w_err !== 16'd4464 || w_beat !== 16'd4464) begin
      errors++;
      $display("FAIL sat_wrap: err %0d beats %0d want 4464 4464", w_err, w_beat);
    end
    checks++;
    if (w_flag !== 1'b1 || s_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_flag: wrap %0b sat %0b want 1 1", w_flag, s_flag);
    end
    checks++;
    if (error_count !== 32'd70000) begin
      errors++;
      $display("FAIL sat_wide: err %0d want 70000", error_count);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_counter();
    test_first_err();
    test_lfsr();
    test_walk_stop_clear();
    test_alt();
    test_reset_mid_run();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
